// File: rtl/pebble_autoplayer_pkg.sv
// Shared definitions for the pebble autoplayer: FSM states, winner codes,
// pit selectors and the move-selection rule.
package pebble_pkg;

  localparam int unsigned PIT_W = 4;

  localparam logic [1:0] WINNER_NONE   = 2'b00;
  localparam logic [1:0] WINNER_CPU    = 2'b01;
  localparam logic [1:0] WINNER_PLAYER = 2'b10;

  localparam logic POS_PIT3 = 1'b0;
  localparam logic POS_PIT4 = 1'b1;

  localparam logic [PIT_W-1:0] PIT_RESET = 4'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECIDE,
    ST_PULSE,
    ST_WAIT_CHANGE,
    ST_SETTLE,
    ST_DONE
  } ap_state_e;

  typedef struct packed {
    logic [PIT_W-1:0] p1;
    logic [PIT_W-1:0] p2;
    logic [PIT_W-1:0] p3;
    logic [PIT_W-1:0] p4;
  } board_t;

  // Only ever returns a nonzero pit when at least one player pit is nonzero.
  function automatic logic pick_pit(input board_t b, input logic policy, input logic rnd);
    logic sel;
    if (b.p3 == '0)         sel = POS_PIT4;
    else if (b.p4 == '0)    sel = POS_PIT3;
    else if (policy)        sel = rnd;
    else if (b.p4 > b.p3)   sel = POS_PIT4;
    else                    sel = POS_PIT3;
    return sel;
  endfunction

endpackage

// File: rtl/pebble_autoplayer_if.sv
// Move interface between the autoplayer (master) and pebble_game (slave).
interface pebble_autoplayer_if;
  import pebble_pkg::*;

  logic [PIT_W-1:0] pos1;
  logic [PIT_W-1:0] pos2;
  logic [PIT_W-1:0] pos3;
  logic [PIT_W-1:0] pos4;
  logic [1:0]       winner;
  logic             play;
  logic             player_position;

  modport master (
    output play, player_position,
    input  pos1, pos2, pos3, pos4, winner
  );

  modport slave (
    input  play, player_position,
    output pos1, pos2, pos3, pos4, winner
  );

endinterface

// File: rtl/pebble_autoplayer_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] q
);

  logic [7:0] lfsr_q;
  logic       fb;

  assign fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= {lfsr_q[6:0], fb};
  end

  assign q = lfsr_q;

endmodule

// File: rtl/pebble_autoplayer.sv
// Self-play engine for pebble_game: reads the board, picks a legal player
// pit, strobes play, then waits for the board to change and settle.
module pebble_autoplayer
  import pebble_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES   = 2,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 policy,
  pebble_autoplayer_if.master  game,
  output logic                 busy,
  output logic                 done,
  output logic                 stuck,
  output logic                 timeout_err,
  output logic [7:0]           move_count
);

  localparam logic [6:0] PULSE_LAST   = 7'(PULSE_CYCLES - 1);
  localparam logic [6:0] SETTLE_LAST  = 7'(SETTLE_CYCLES - 1);
  localparam logic [6:0] TIMEOUT_LAST = 7'(TIMEOUT_CYCLES - 1);

  ap_state_e  state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  board_t     board_q, board_d;
  board_t     prev_q;
  board_t     board_now;
  logic       pos_q, pos_d;
  logic       stuck_q, stuck_d;
  logic       tout_q, tout_d;
  logic [7:0] mcnt_q, mcnt_d;
  logic       play_q, busy_q, done_q;
  logic       game_over;

  logic [7:0] lfsr_q;
  logic [6:0] lfsr_unused;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign lfsr_unused = lfsr_q[7:1];
  assign board_now   = {game.pos1, game.pos2, game.pos3, game.pos4};
  assign game_over   = (game.winner != WINNER_NONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    board_d = board_q;
    pos_d   = pos_q;
    stuck_d = stuck_q;
    tout_d  = tout_q;
    mcnt_d  = mcnt_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_DECIDE;
          cnt_d   = '0;
          mcnt_d  = '0;
          stuck_d = 1'b0;
          tout_d  = 1'b0;
        end
      end

      ST_DECIDE: begin
        cnt_d = '0;
        if (game_over) begin
          state_d = ST_DONE;
        end else if (board_now.p3 == '0 && board_now.p4 == '0) begin
          stuck_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          pos_d   = pick_pit(board_now, policy, lfsr_q[0]);
          board_d = board_now;
          mcnt_d  = (mcnt_q == '1) ? mcnt_q : mcnt_q + 8'd1;
          state_d = ST_PULSE;
        end
      end

      ST_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT_CHANGE;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end

      ST_WAIT_CHANGE: begin
        if (game_over) begin
          state_d = ST_DONE;
        end else if (board_now != board_q) begin
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          tout_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end

      // Counter holds the number of consecutive unchanged cycles seen so far.
      ST_SETTLE: begin
        if (game_over) begin
          state_d = ST_DONE;
        end else if (board_now != prev_q) begin
          cnt_d = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_DECIDE;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      board_q <= '0;
      prev_q  <= '0;
      pos_q   <= POS_PIT3;
      stuck_q <= 1'b0;
      tout_q  <= 1'b0;
      mcnt_q  <= '0;
      play_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      board_q <= board_d;
      prev_q  <= board_now;
      pos_q   <= pos_d;
      stuck_q <= stuck_d;
      tout_q  <= tout_d;
      mcnt_q  <= mcnt_d;
      // Status flags are decoded from the next state so they stay glitch-free flops.
      play_q  <= (state_d == ST_PULSE);
      busy_q  <= !(state_d inside {ST_IDLE, ST_DONE});
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign game.play            = play_q;
  assign game.player_position = pos_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign stuck                = stuck_q;
  assign timeout_err          = tout_q;
  assign move_count           = mcnt_q;

endmodule
